// File: rtl/datactrl.sv
// Byte-serial load/store controller between the load/store buffers and an
// 8-bit synchronous RAM. One pending slot per client; stores win over loads.
// Loads are pipelined one byte per cycle against the RAM's one-cycle read
// latency; a misprediction flush kills load work but never store work.
module datactrl #(
  parameter int AddressWidth = 32,
  parameter int IDWidth      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    lbuffer_datactrl_en_in,
  input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]              lbuffer_datactrl_width_in,
  input  logic                    lbuffer_datactrl_sgn_in,
  output logic                    datactrl_lbuffer_en_out,
  output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
  input  logic                    sbuffer_datactrl_en_in,
  input  logic [AddressWidth-1:0] sbuffer_datactrl_addr_in,
  input  logic [2:0]              sbuffer_datactrl_width_in,
  input  logic [IDWidth-1:0]      sbuffer_datactrl_data_in,
  output logic                    datactrl_sbuffer_en_out,
  input  logic                    rob_datactrl_rst_in,
  output logic [AddressWidth-1:0] mem_a_out,
  output logic [7:0]              mem_dout_out,
  output logic                    mem_wr_out,
  input  logic [7:0]              mem_din_in
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  // Width codes 1 and 2 are honoured; anything else is a full word.
  function automatic logic [2:0] decode_width(input logic [2:0] code);
    case (code)
      3'd1:    decode_width = 3'd1;
      3'd2:    decode_width = 3'd2;
      default: decode_width = 3'd4;
    endcase
  endfunction

  state_t                  state_reg;

  // pending request slots
  logic                    ld_pend_reg;
  logic [AddressWidth-1:0] ld_addr_reg;
  logic [2:0]              ld_w_reg;
  logic                    ld_sgn_reg;
  logic                    st_pend_reg;
  logic [AddressWidth-1:0] st_addr_reg;
  logic [2:0]              st_w_reg;
  logic [IDWidth-1:0]      st_data_reg;

  // active access
  logic [AddressWidth-1:0] base_reg;
  logic [2:0]              w_reg;
  logic                    sgn_reg;
  logic [IDWidth-1:0]      data_reg;
  logic [2:0]              idx_reg;      // next byte index to put on the bus
  logic [2:0]              cap_reg;      // next load byte index to capture
  logic                    addr_on_reg;  // a load address is on the bus this cycle
  logic                    rd_valid_reg; // mem_din_in carries byte cap_reg this cycle
  logic                    replay_reg;   // a stall broke the load pipeline
  logic [31:0]             acc_reg;

  // registered outputs
  logic [AddressWidth-1:0] mem_a_reg;
  logic [7:0]              mem_dout_reg;
  logic                    mem_wr_reg;
  logic                    ld_done_reg;
  logic [IDWidth-1:0]      ld_data_reg;
  logic                    st_done_reg;

  logic [7:0]              st_lane [4];
  logic [31:0]             ld_word;
  logic [IDWidth-1:0]      ld_ext;
  logic                    flush_abort;
  logic                    ld_finish;
  logic                    st_finish;
  logic                    free;
  logic                    start_store;
  logic                    start_load;

  // Byte lanes: store byte selection and load word with the arriving byte merged in.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign st_lane[gi]        = data_reg[8*gi +: 8];
      assign ld_word[8*gi +: 8] = (cap_reg == 3'(gi)) ? mem_din_in : acc_reg[8*gi +: 8];
    end
  endgenerate

  // Sign- or zero-extend the completed load word according to its width.
  always_comb begin
    ld_ext = IDWidth'(ld_word);
    case (w_reg)
      3'd1:    ld_ext = sgn_reg ? IDWidth'($signed(ld_word[7:0]))  : IDWidth'(ld_word[7:0]);
      3'd2:    ld_ext = sgn_reg ? IDWidth'($signed(ld_word[15:0])) : IDWidth'(ld_word[15:0]);
      default: ;
    endcase
  end

  assign flush_abort = rob_datactrl_rst_in && (state_reg == LOAD);
  assign ld_finish   = (state_reg == LOAD) && !replay_reg && rd_valid_reg &&
                       (cap_reg == w_reg - 3'd1);
  assign st_finish   = (state_reg == STORE) && (idx_reg == w_reg);
  assign free        = (state_reg == IDLE) || ld_finish || st_finish;
  assign start_store = st_pend_reg;
  assign start_load  = !st_pend_reg && ld_pend_reg && !rob_datactrl_rst_in;

  // Request capture, access sequencing and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      ld_pend_reg  <= 1'b0;
      ld_addr_reg  <= '0;
      ld_w_reg     <= '0;
      ld_sgn_reg   <= 1'b0;
      st_pend_reg  <= 1'b0;
      st_addr_reg  <= '0;
      st_w_reg     <= '0;
      st_data_reg  <= '0;
      base_reg     <= '0;
      w_reg        <= '0;
      sgn_reg      <= 1'b0;
      data_reg     <= '0;
      idx_reg      <= '0;
      cap_reg      <= '0;
      addr_on_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      replay_reg   <= 1'b0;
      acc_reg      <= '0;
      mem_a_reg    <= '0;
      mem_dout_reg <= '0;
      mem_wr_reg   <= 1'b0;
      ld_done_reg  <= 1'b0;
      ld_data_reg  <= '0;
      st_done_reg  <= 1'b0;
    end else begin
      ld_done_reg <= 1'b0;
      st_done_reg <= 1'b0;

      // Requests are captured even during a stall so no pulse is lost.
      if (sbuffer_datactrl_en_in) begin
        st_pend_reg <= 1'b1;
        st_addr_reg <= sbuffer_datactrl_addr_in;
        st_w_reg    <= decode_width(sbuffer_datactrl_width_in);
        st_data_reg <= sbuffer_datactrl_data_in;
      end
      if (rob_datactrl_rst_in) begin
        ld_pend_reg <= 1'b0;
      end else if (lbuffer_datactrl_en_in) begin
        ld_pend_reg <= 1'b1;
        ld_addr_reg <= lbuffer_datactrl_addr_in;
        ld_w_reg    <= decode_width(lbuffer_datactrl_width_in);
        ld_sgn_reg  <= lbuffer_datactrl_sgn_in;
      end

      if (flush_abort) begin
        state_reg    <= IDLE;
        mem_a_reg    <= '0;
        mem_dout_reg <= '0;
        mem_wr_reg   <= 1'b0;
        addr_on_reg  <= 1'b0;
        rd_valid_reg <= 1'b0;
        replay_reg   <= 1'b0;
      end else if (!rdy_in) begin
        // The RAM keeps reading while we hold, so the in-flight load byte is stale.
        if (state_reg == LOAD) replay_reg <= 1'b1;
      end else begin
        case (state_reg)
          LOAD: begin
            if (replay_reg) begin
              mem_a_reg    <= base_reg + AddressWidth'(cap_reg);
              idx_reg      <= cap_reg + 3'd1;
              addr_on_reg  <= 1'b1;
              rd_valid_reg <= 1'b0;
              replay_reg   <= 1'b0;
            end else begin
              if (rd_valid_reg) begin
                acc_reg <= ld_word;
                cap_reg <= cap_reg + 3'd1;
              end
              rd_valid_reg <= addr_on_reg;
              if (idx_reg < w_reg) begin
                mem_a_reg   <= base_reg + AddressWidth'(idx_reg);
                idx_reg     <= idx_reg + 3'd1;
                addr_on_reg <= 1'b1;
              end else begin
                addr_on_reg <= 1'b0;
              end
              if (ld_finish) begin
                ld_done_reg <= 1'b1;
                ld_data_reg <= ld_ext;
              end
            end
          end
          STORE: begin
            if (st_finish) begin
              st_done_reg <= 1'b1;
            end else begin
              mem_a_reg    <= base_reg + AddressWidth'(idx_reg);
              mem_dout_reg <= st_lane[idx_reg[1:0]];
              idx_reg      <= idx_reg + 3'd1;
            end
          end
          default: ;
        endcase

        // Launch the next request on the same edge an access finishes.
        if (free) begin
          if (start_store) begin
            state_reg    <= STORE;
            st_pend_reg  <= 1'b0;
            base_reg     <= st_addr_reg;
            w_reg        <= st_w_reg;
            data_reg     <= st_data_reg;
            mem_a_reg    <= st_addr_reg;
            mem_dout_reg <= st_data_reg[7:0];
            mem_wr_reg   <= 1'b1;
            idx_reg      <= 3'd1;
          end else if (start_load) begin
            state_reg    <= LOAD;
            ld_pend_reg  <= 1'b0;
            base_reg     <= ld_addr_reg;
            w_reg        <= ld_w_reg;
            sgn_reg      <= ld_sgn_reg;
            mem_a_reg    <= ld_addr_reg;
            mem_dout_reg <= '0;
            mem_wr_reg   <= 1'b0;
            idx_reg      <= 3'd1;
            cap_reg      <= 3'd0;
            addr_on_reg  <= 1'b1;
            rd_valid_reg <= 1'b0;
            replay_reg   <= 1'b0;
            acc_reg      <= '0;
          end else begin
            state_reg    <= IDLE;
            mem_a_reg    <= '0;
            mem_dout_reg <= '0;
            mem_wr_reg   <= 1'b0;
            addr_on_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
          end
        end
      end
    end
  end

  assign mem_a_out                 = mem_a_reg;
  assign mem_dout_out              = mem_dout_reg;
  assign mem_wr_out                = mem_wr_reg && rdy_in;
  assign datactrl_lbuffer_en_out   = ld_done_reg;
  assign datactrl_lbuffer_data_out = ld_data_reg;
  assign datactrl_sbuffer_en_out   = st_done_reg;

endmodule

// File: tb/tb_datactrl.sv
// Directed bench for datactrl: a small synchronous byte RAM with one-cycle
// read latency, hand-computed expected bus activity, results and pulse counts.
module tb_datactrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        lb_en, lb_sgn;
  logic [31:0] lb_addr;
  logic [2:0]  lb_w;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        sb_en;
  logic [31:0] sb_addr, sb_data;
  logic [2:0]  sb_w;
  logic        st_done;
  logic        flush;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr;

  logic [7:0]  ram [4096];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [7:0]  bd_data;

  int chk_cnt = 0;
  int err_cnt = 0;
  int ld_pulses = 0;
  int st_pulses = 0;
  int n, ld0, st0;

  always #5 clk_in = ~clk_in;

  datactrl dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .lbuffer_datactrl_en_in    (lb_en),
    .lbuffer_datactrl_addr_in  (lb_addr),
    .lbuffer_datactrl_width_in (lb_w),
    .lbuffer_datactrl_sgn_in   (lb_sgn),
    .datactrl_lbuffer_en_out   (ld_done),
    .datactrl_lbuffer_data_out (ld_data),
    .sbuffer_datactrl_en_in    (sb_en),
    .sbuffer_datactrl_addr_in  (sb_addr),
    .sbuffer_datactrl_width_in (sb_w),
    .sbuffer_datactrl_data_in  (sb_data),
    .datactrl_sbuffer_en_out   (st_done),
    .rob_datactrl_rst_in       (flush),
    .mem_a_out                 (mem_a),
    .mem_dout_out              (mem_dout),
    .mem_wr_out                (mem_wr),
    .mem_din_in                (mem_din)
  );

  // RAM model: read-first, one-cycle read latency, plus a backdoor preload port.
  always @(posedge clk_in) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  // Done-pulse counters.
  always @(posedge clk_in) begin
    if (ld_done) ld_pulses <= ld_pulses + 1;
    if (st_done) st_pulses <= st_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic load_req(input logic [31:0] a, input logic [2:0] w, input logic s);
    lb_en = 1'b1; lb_addr = a; lb_w = w; lb_sgn = s;
    tick();
    lb_en = 1'b0;
  endtask

  task automatic store_req(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
    sb_en = 1'b1; sb_addr = a; sb_w = w; sb_data = d;
    tick();
    sb_en = 1'b0;
  endtask

  // Wait up to max negedges for a done pulse (0 = load, 1 = store); n = edges waited.
  task automatic wait_done(input string tag, input int which, input int max, output int cnt);
    logic seen;
    seen = 1'b0;
    cnt = 0;
    while (!seen && cnt < max) begin
      tick();
      cnt++;
      seen = (which == 0) ? ld_done : st_done;
    end
    if (!seen) check({tag, "_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    lb_en = 1'b0; lb_addr = '0; lb_w = '0; lb_sgn = 1'b0;
    sb_en = 1'b0; sb_addr = '0; sb_w = '0; sb_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    tick(); tick();
    poke(12'h100, 8'h80); poke(12'h101, 8'hF0);
    poke(12'h200, 8'h11); poke(12'h201, 8'h22); poke(12'h202, 8'h33); poke(12'h203, 8'h44);
    poke(12'h300, 8'h00); poke(12'h301, 8'h00); poke(12'h302, 8'h5A);
    poke(12'h400, 8'h00); poke(12'h500, 8'h00);
    for (int i = 0; i < 4; i++) begin
      poke(12'h600 + 12'(i), 8'h00);
      poke(12'h680 + 12'(i), 8'h00);
      poke(12'h700 + 12'(i), 8'h00);
    end
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_ctrl", {27'd0, ld_done, st_done, mem_wr, 2'b00}, 32'h0);
    check("rst_dout_ld_data", ld_data | {24'd0, mem_dout}, 32'h0);
    rst_in = 1'b0;
    tick();

    // LB signed at 0x100 -> 0xFFFFFF80, done two edges after start
    load_req(32'h100, 3'd1, 1'b1);
    check("lb_capture_idle_addr", mem_a, 32'h0);
    tick();
    check("lb_addr", mem_a, 32'h100);
    check("lb_wr_low", {31'd0, mem_wr}, 32'd0);
    tick();
    check("lb_no_early_done", {31'd0, ld_done}, 32'd0);
    tick();
    check("lb_done", {31'd0, ld_done}, 32'd1);
    check("lb_data", ld_data, 32'hFFFF_FF80);
    tick();
    check("lb_done_one_cycle", {31'd0, ld_done}, 32'd0);
    check("lb_idle_addr", mem_a, 32'h0);

    // LBU same address -> zero-extended
    load_req(32'h100, 3'd1, 1'b0);
    wait_done("lbu", 0, 10, n);
    check("lbu_latency", n, 32'd3);
    check("lbu_data", ld_data, 32'h0000_0080);

    // LH signed at 0x100 -> sign from bit 15
    load_req(32'h100, 3'd2, 1'b1);
    wait_done("lh", 0, 10, n);
    check("lh_latency", n, 32'd4);
    check("lh_data", ld_data, 32'hFFFF_F080);

    // LW at 0x200: one address per cycle, result at start+5
    load_req(32'h200, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("lw_addr%0d", i), mem_a, 32'h200 + i);
    end
    tick();
    check("lw_no_early_done", {31'd0, ld_done}, 32'd0);
    tick();
    check("lw_done", {31'd0, ld_done}, 32'd1);
    check("lw_data", ld_data, 32'h4433_2211);

    // Illegal width code 7 behaves as a word
    load_req(32'h200, 3'd7, 1'b1);
    wait_done("lw7", 0, 12, n);
    check("lw7_latency", n, 32'd6);
    check("lw7_data", ld_data, 32'h4433_2211);

    // SH at 0x300
    store_req(32'h300, 3'd2, 32'hDEAD_BEEF);
    tick();
    check("sh_b0", {mem_wr, 15'd0, mem_dout, mem_a[7:0]}, {1'b1, 15'd0, 8'hEF, 8'h00});
    tick();
    check("sh_b1", {mem_wr, 15'd0, mem_dout, mem_a[7:0]}, {1'b1, 15'd0, 8'hBE, 8'h01});
    check("sh_b1_addr", mem_a, 32'h301);
    tick();
    check("sh_done", {30'd0, st_done, mem_wr}, 32'b10);
    tick();
    check("sh_done_one_cycle", {31'd0, st_done}, 32'd0);
    check("sh_ram", {8'd0, ram[12'h302], ram[12'h301], ram[12'h300]}, 32'h005A_BEEF);

    // Load and store pulses in the same cycle
    ld0 = ld_pulses; st0 = st_pulses;
    lb_en = 1'b1; lb_addr = 32'h400; lb_w = 3'd1; lb_sgn = 1'b0;
    sb_en = 1'b1; sb_addr = 32'h400; sb_w = 3'd1; sb_data = 32'h0000_0177;
    tick();
    lb_en = 1'b0; sb_en = 1'b0;
    tick();
    check("both_store_first", {mem_wr, mem_a[30:0]}, {1'b1, 31'h400});
    tick();
    check("both_store_done", {30'd0, st_done, mem_wr}, 32'b10);
    check("both_load_starts", mem_a, 32'h400);
    tick();
    tick();
    check("both_load_done", {31'd0, ld_done}, 32'd1);
    check("both_load_data", ld_data, 32'h0000_0077);
    tick(); tick(); tick();
    check("both_pulse_counts", {ld_pulses - ld0, st_pulses - st0}, {32'd1, 32'd1} >> 32);
    check("both_ld_count", ld_pulses - ld0, 32'd1);

    // Flush during LW byte 2 with a store pending
    ld0 = ld_pulses; st0 = st_pulses;
    load_req(32'h200, 3'd4, 1'b0);
    tick();
    store_req(32'h500, 3'd1, 32'h0000_0099);
    tick();
    check("flush_byte2_addr", mem_a, 32'h202);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_abort_idle", {mem_wr, mem_a[30:0]}, 32'h0);
    tick();
    check("flush_store_next", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'h99, 16'h0500});
    tick();
    check("flush_store_done", {31'd0, st_done}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("flush_no_ld_done", ld_pulses - ld0, 32'd0);
    check("flush_store_ram", {24'd0, ram[12'h500]}, 32'h99);

    // Flush drops a pending load (store running) and a same-cycle load request
    ld0 = ld_pulses; st0 = st_pulses;
    lb_en = 1'b1; lb_addr = 32'h100; lb_w = 3'd1; lb_sgn = 1'b0;
    sb_en = 1'b1; sb_addr = 32'h600; sb_w = 3'd4; sb_data = 32'h0102_0304;
    tick();
    lb_en = 1'b0; sb_en = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pend_flush_st_done", st_pulses - st0, 32'd1);
    check("pend_flush_no_ld", ld_pulses - ld0, 32'd0);
    check("pend_flush_ram",
          {ram[12'h603], ram[12'h602], ram[12'h601], ram[12'h600]}, 32'h0102_0304);
    ld0 = ld_pulses;
    flush = 1'b1;
    load_req(32'h100, 3'd1, 1'b0);
    flush = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("same_cycle_flush_no_ld", ld_pulses - ld0, 32'd0);
    check("same_cycle_flush_idle", mem_a, 32'h0);

    // rdy low for 3 cycles mid-LW
    load_req(32'h200, 3'd4, 1'b0);
    tick(); tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_ld_wr_low%0d", i), {31'd0, mem_wr}, 32'd0);
      tick();
    end
    rdy_in = 1'b1;
    wait_done("stall_lw", 0, 20, n);
    check("stall_lw_data", ld_data, 32'h4433_2211);

    // rdy low mid-SW: no write while stalled, data intact afterwards
    store_req(32'h680, 3'd4, 32'hCAFE_F00D);
    tick();
    rdy_in = 1'b0;
    #1;
    check("stall_st_wr_low", {31'd0, mem_wr}, 32'd0);
    tick(); tick();
    rdy_in = 1'b1;
    wait_done("stall_sw", 1, 20, n);
    tick();
    check("stall_sw_ram",
          {ram[12'h683], ram[12'h682], ram[12'h681], ram[12'h680]}, 32'hCAFE_F00D);

    // Reset in the middle of a word store
    st0 = st_pulses;
    store_req(32'h700, 3'd4, 32'h5566_7788);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("midrst_outputs", {mem_wr, mem_a[30:0]}, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_done", st_pulses - st0, 32'd0);
    check("midrst_no_more_writes", {8'd0, ram[12'h703], ram[12'h702], ram[12'h701]}, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/datactrl.md
DATACTRL -- requirements
Module: datactrl

Interface
REQ-001 SHALL use constant AddressWidth, default 32, meaning the memory address width (from constant.vh).
REQ-002 SHALL use constant IDWidth, default 32, meaning the load/store data word width (from constant.vh).
REQ-003 SHALL have clk_in  input  1  system clock; all state on posedge.
REQ-004 SHALL have rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have rdy_in  input  1  global enable; low means stall.
REQ-006 SHALL have lbuffer_datactrl_en_in  input  1  one-cycle load request pulse.
REQ-007 SHALL have lbuffer_datactrl_addr_in  input  AddressWidth  load byte address.
REQ-008 SHALL have lbuffer_datactrl_width_in  input  3  load bytes, 1/2/4.
REQ-009 SHALL have lbuffer_datactrl_sgn_in  input  1  1 means sign-extend.
REQ-010 SHALL have datactrl_lbuffer_en_out  output  1  one-cycle load-done pulse.
REQ-011 SHALL have datactrl_lbuffer_data_out  output  IDWidth  extended load result, valid with the done pulse.
REQ-012 SHALL have sbuffer_datactrl_en_in  input  1  one-cycle store request pulse.
REQ-013 SHALL have sbuffer_datactrl_addr_in / _width_in / _data_in  input  AddressWidth / 3 / IDWidth  store address, byte count, data (low bytes used).
REQ-014 SHALL have datactrl_sbuffer_en_out  output  1  one-cycle store-done pulse.
REQ-015 SHALL have rob_datactrl_rst_in  input  1  misprediction flush.
REQ-016 SHALL have mem_a_out  output  AddressWidth  RAM byte address.
REQ-017 SHALL have mem_dout_out  output  8  RAM write byte.
REQ-018 SHALL have mem_wr_out  output  1  1 means write.
REQ-019 SHALL have mem_din_in  input  8  RAM read byte, valid one cycle after its address.

Function
REQ-020 SHALL latch every request pulse into a per-client pending slot at the sampling edge, in any state.
REQ-021 SHALL run FSM states IDLE, LOAD, STORE; from IDLE it SHALL start a pending store in preference to a pending load, starting at the edge after capture.
REQ-022 SHALL treat a width code other than 1/2/4 as 4.
REQ-023 SHALL, on a load of w bytes at address A, drive mem_a_out=A+i with mem_wr_out=0 in cycle i+1 after start (i=0..w-1), little-endian.
REQ-024 SHALL sample each load byte at the edge after its address cycle.
REQ-025 SHALL assert the load-done pulse and data at the edge after the last sample, giving latency w+1 edges from the start edge.
REQ-026 SHALL, on a store of w bytes at address A, drive mem_a_out=A+i, mem_dout_out=data[8i+7:8i] and mem_wr_out=1 in cycle i+1 (i=0..w-1).
REQ-027 SHALL raise the store-done pulse in cycle w+1.
REQ-028 SHALL sign-extend the load result from bit 8w-1 when sgn=1 and w<4, and zero-extend otherwise.
REQ-029 SHALL start the next pending request at the done edge (back-to-back, no idle cycle).
REQ-030 SHALL, outside an active access, drive mem_wr_out=0 and mem_a_out=0.
REQ-031 SHALL hold done pulses for exactly one cycle, deasserted otherwise.
REQ-032 SHALL treat a second request from the same client before its done pulse as a protocol violation; behaviour is undefined and the bench SHALL not generate it.
REQ-033 SHALL, on rob_datactrl_rst_in, drop the pending load.
REQ-034 SHALL, on rob_datactrl_rst_in, abort an in-flight load with no done pulse.
REQ-035 SHALL, on rob_datactrl_rst_in, drop a load request sampled in the same cycle.
REQ-036 SHALL complete an in-flight store and keep a pending store across rob_datactrl_rst_in.
REQ-037 SHALL, while rdy_in=0, hold all state and force mem_wr_out=0.
REQ-038 SHALL, on rdy_in returning to 1, re-present the current byte's address, discarding any read data that arrived during the stall.

Reset
REQ-039 SHALL, at rst_in=1, clear FSM to IDLE, clear both pending slots and zero every output, taking priority over rdy_in and the flush.
REQ-040 SHALL, on reset mid-access, emit no further writes and no done pulse.

Verification
REQ-041 SHALL cover: LB at A=0x100, RAM[0x100]=0x80, sgn=1 -> data 0xFFFFFF80 with done 2 edges after start; same request as LBU -> 0x00000080.
REQ-042 SHALL cover: LW at 0x200 holding bytes 11,22,33,44 -> addresses 0x200..0x203 in cycles 1..4, data 0x44332211 at edge 5.
REQ-043 SHALL cover: SH at 0x300 with data 0xDEADBEEF -> writes EF@0x300, BE@0x301, then store-done pulse, and RAM[0x302] unchanged.
REQ-044 SHALL cover: load and store pulses in the same cycle -> store serviced first, load starts at the store-done edge, and both done pulses occur once.
REQ-045 SHALL cover: flush during LW byte 2 while a store is pending -> no load-done pulse, and the store executes next.
REQ-046 SHALL cover: rdy_in low for 3 cycles mid-LW -> result identical to the unstalled case, and mem_wr_out stays 0.
